ps_sc_pkt_fifo: RTL and testbench



---
 rtl/ps_fifo_pkg.sv | 12 +
 rtl/ps_sc_ram.sv | 25 ++
 rtl/ps_sc_pkt_fifo.sv | 87 ++++++++
 tb/tb_ps_sc_pkt_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps_fifo_pkg.sv
// PacketStream FIFO shared definitions.
// Mode names and the counter width helper.
package ps_fifo_pkg;

  localparam PS_FIFO_STREAM = "STREAM";
  localparam PS_FIFO_PACKET = "PACKET";

  function automatic int ps_fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ps_sc_ram.sv
// Simple dual-port RAM for the PacketStream FIFO.
// Synchronous write, asynchronous show-ahead read.
module ps_sc_ram #(
  parameter int WIDTH   = 9,
  parameter int DEPTH   = 16,
  parameter     RAMTYPE = "MLAB"
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  (* ram_block_type = RAMTYPE *)
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ps_sc_pkt_fifo.sv
// Single-clock PacketStream FIFO.
// Cut-through or store-and-forward with oversize release.
module ps_sc_pkt_fifo
  import ps_fifo_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 16,
  parameter     MODE    = "STREAM",
  parameter     RAMTYPE = "MLAB"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        i_dat,
  input  logic                     i_val,
  input  logic                     i_eop,
  output logic                     i_rdy,
  output logic [DWIDTH-1:0]        o_dat,
  output logic                     o_val,
  output logic                     o_eop,
  input  logic                     o_rdy,
  output logic [$clog2(DEPTH):0]   o_used,
  output logic [$clog2(DEPTH):0]   o_pkts
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = ps_fifo_cw(DEPTH);
  localparam bit PKT = (MODE == PS_FIFO_PACKET);

  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   used;
  logic [CW-1:0]   pkts;
  logic            rel;
  logic            wr;
  logic            rd;
  logic            full;
  logic            empty;
  logic [DWIDTH:0] rd_word;

  assign full  = (used == CW'(DEPTH));
  assign empty = (used == '0);
  assign i_rdy = ~full;
  assign wr    = i_val & i_rdy;
  assign rd    = o_val & o_rdy;

  // Packet mode waits for a whole packet unless it can never fit.
  assign o_val = PKT ? (~empty & ((pkts != '0) | rel))
                     : ~empty;

  assign o_dat  = rd_word[DWIDTH:1];
  assign o_eop  = rd_word[0];
  assign o_used = used;
  assign o_pkts = pkts;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      pkts   <= '0;
      rel    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + CW'(1);
      if (rd) rd_ptr <= rd_ptr + CW'(1);
      used <= used + CW'(wr) - CW'(rd);
      pkts <= pkts + CW'(wr & i_eop) - CW'(rd & o_eop);
      if (rd & o_eop)
        rel <= 1'b0;
      else if (PKT && full && pkts == '0)
        rel <= 1'b1;
    end
  end

  ps_sc_ram #(
    .WIDTH   (DWIDTH + 1),
    .DEPTH   (DEPTH),
    .RAMTYPE (RAMTYPE)
  ) u_ram (
    .clk   (clk),
    .we    (wr & ~reset),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({i_dat, i_eop}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_ps_sc_pkt_fifo.sv
// Directed bench for ps_sc_pkt_fifo.
// STREAM depth-16 and PACKET depth-8 instances share one clock.
module tb_ps_sc_pkt_fifo;

  logic clk = 1'b0;
  logic reset;

  logic [7:0] s_dat, s_odat;
  logic       s_val, s_eop, s_rdy, s_oval, s_oeop, s_ordy;
  logic [4:0] s_used, s_pkts;

  logic [7:0] p_dat, p_odat;
  logic       p_val, p_eop, p_rdy, p_oval, p_oeop, p_ordy;
  logic [3:0] p_used, p_pkts;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ps_sc_pkt_fifo #(
    .DWIDTH(8), .DEPTH(16), .MODE("STREAM"), .RAMTYPE("MLAB")
  ) u_s (
    .clk(clk), .reset(reset),
    .i_dat(s_dat), .i_val(s_val), .i_eop(s_eop), .i_rdy(s_rdy),
    .o_dat(s_odat), .o_val(s_oval), .o_eop(s_oeop), .o_rdy(s_ordy),
    .o_used(s_used), .o_pkts(s_pkts)
  );

  ps_sc_pkt_fifo #(
    .DWIDTH(8), .DEPTH(8), .MODE("PACKET"), .RAMTYPE("MLAB")
  ) u_p (
    .clk(clk), .reset(reset),
    .i_dat(p_dat), .i_val(p_val), .i_eop(p_eop), .i_rdy(p_rdy),
    .o_dat(p_odat), .o_val(p_oval), .o_eop(p_oeop), .o_rdy(p_ordy),
    .o_used(p_used), .o_pkts(p_pkts)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // No write may land on a full FIFO, no read may leave an empty one.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      assert (!(s_val && s_rdy && s_used == 5'd16) &&
              !(p_val && p_rdy && p_used == 4'd8) &&
              !(s_oval && s_ordy && s_used == 5'd0) &&
              !(p_oval && p_ordy && p_used == 4'd0)) else begin
        n_err++;
        $error("FAIL overflow_underflow observed=1 expected=0");
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wi, ri, cyc;
    bit seen;
    reset = 1'b1;
    s_dat = '0; s_val = 0; s_eop = 0; s_ordy = 0;
    p_dat = '0; p_val = 0; p_eop = 0; p_ordy = 0;
    step();
    step();
    reset = 1'b0;
    chk("rst_s_used", s_used, 0);
    chk("rst_s_pkts", s_pkts, 0);
    chk("rst_s_oval", s_oval, 0);
    chk("rst_s_irdy", s_rdy, 1);
    chk("rst_p_used", p_used, 0);
    chk("rst_p_oval", p_oval, 0);
    chk("rst_p_irdy", p_rdy, 1);

    // STREAM fill to 16 then drain in order
    for (int i = 0; i < 16; i++) begin
      s_val = 1; s_dat = 8'(i); s_eop = (i == 15);
      chk("fill_irdy", s_rdy, 1);
      step();
    end
    s_val = 0; s_eop = 0;
    chk("full_used", s_used, 16);
    chk("full_irdy", s_rdy, 0);
    chk("full_pkts", s_pkts, 1);
    chk("full_oval", s_oval, 1);
    s_ordy = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_oval", s_oval, 1);
      chk("drain_dat", s_odat, i);
      chk("drain_eop", s_oeop, (i == 15) ? 1 : 0);
      step();
    end
    s_ordy = 0;
    chk("drained_used", s_used, 0);
    chk("drained_pkts", s_pkts, 0);
    chk("drained_oval", s_oval, 0);
    chk("drained_irdy", s_rdy, 1);

    // Full with simultaneous read: read only, then write accepted
    for (int i = 0; i < 16; i++) begin
      s_val = 1; s_dat = 8'(32 + i); s_eop = 0;
      step();
    end
    s_val = 1; s_dat = 8'h55; s_eop = 1; s_ordy = 1;
    chk("fr_irdy0", s_rdy, 0);
    chk("fr_head0", s_odat, 32);
    step();
    chk("fr_used1", s_used, 15);
    chk("fr_irdy1", s_rdy, 1);
    chk("fr_head1", s_odat, 33);
    step();
    s_val = 0; s_eop = 0;
    chk("fr_used2", s_used, 15);
    chk("fr_pkts2", s_pkts, 1);
    for (int i = 0; i < 15; i++) begin
      chk("fr_dat", s_odat, (i == 14) ? 8'h55 : 34 + i);
      chk("fr_eop", s_oeop, (i == 14) ? 1 : 0);
      step();
    end
    chk("fr_end_used", s_used, 0);
    chk("fr_end_pkts", s_pkts, 0);

    // Continuous flow, pointers wrap past 32
    s_ordy = 1;
    s_val = 1; s_dat = 8'd0; s_eop = 0;
    chk("cf_oval_pre", s_oval, 0);
    step();
    chk("cf_oval_first", s_oval, 1);
    chk("cf_used_first", s_used, 1);
    for (int k = 1; k < 40; k++) begin
      s_dat = 8'(k);
      chk("cf_dat", s_odat, k - 1);
      step();
      chk("cf_used", s_used, 1);
    end
    s_val = 0;
    chk("cf_last", s_odat, 39);
    step();
    chk("cf_end_used", s_used, 0);
    chk("cf_end_oval", s_oval, 0);
    s_ordy = 0;

    // PACKET 5 beats with idle gaps
    for (int i = 0; i < 5; i++) begin
      p_val = 1; p_dat = 8'(8'hA0 + i); p_eop = (i == 4);
      step();
      p_val = 0; p_eop = 0;
      if (i < 4) begin
        chk("pk5_hold", p_oval, 0);
        step();
        chk("pk5_idle", p_oval, 0);
      end
    end
    chk("pk5_oval", p_oval, 1);
    chk("pk5_pkts", p_pkts, 1);
    chk("pk5_used", p_used, 5);
    p_ordy = 1;
    for (int i = 0; i < 5; i++) begin
      chk("pk5_rd_val", p_oval, 1);
      chk("pk5_rd_dat", p_odat, 8'hA0 + i);
      chk("pk5_rd_eop", p_oeop, (i == 4) ? 1 : 0);
      step();
    end
    chk("pk5_end_pkts", p_pkts, 0);
    chk("pk5_end_used", p_used, 0);
    chk("pk5_end_oval", p_oval, 0);

    // PACKET oversize 12 beats into depth 8
    wi = 0; ri = 0; cyc = 0; seen = 0;
    while (ri < 12 && cyc < 200) begin
      p_val = (wi < 12);
      p_dat = 8'(8'hB0 + wi);
      p_eop = (wi == 11);
      if (p_oval) begin
        if (!seen) chk("ovs_rel_used", p_used, 8);
        seen = 1;
        chk("ovs_dat", p_odat, 8'hB0 + ri);
        chk("ovs_eop", p_oeop, (ri == 11) ? 1 : 0);
        ri++;
      end else if (!seen) begin
        chk("ovs_wait", (p_used != 0) ? 1 : 0, (wi > 0) ? 1 : 0);
      end
      if (p_val && p_rdy) wi++;
      step();
      cyc++;
    end
    p_val = 0; p_eop = 0;
    chk("ovs_count", ri, 12);
    chk("ovs_end_used", p_used, 0);
    chk("ovs_end_pkts", p_pkts, 0);
    p_val = 1; p_dat = 8'hD0;
    step();
    p_val = 0;
    chk("ovs_rel_clr", p_oval, 0);
    p_val = 1; p_dat = 8'hD1; p_eop = 1;
    step();
    p_val = 0; p_eop = 0;
    chk("ovs_nxt_val", p_oval, 1);
    chk("ovs_nxt_dat0", p_odat, 8'hD0);
    step();
    chk("ovs_nxt_dat1", p_odat, 8'hD1);
    chk("ovs_nxt_eop1", p_oeop, 1);
    step();
    chk("ovs_nxt_used", p_used, 0);

    // Reset mid-packet with 7 beats stored
    p_ordy = 0;
    for (int i = 0; i < 7; i++) begin
      p_val = 1; p_dat = 8'(i); p_eop = 0;
      step();
    end
    chk("mr_used7", p_used, 7);
    reset = 1; p_dat = 8'hEE; p_eop = 1;
    step();
    reset = 0; p_val = 0; p_eop = 0;
    chk("mr_used", p_used, 0);
    chk("mr_pkts", p_pkts, 0);
    chk("mr_oval", p_oval, 0);
    chk("mr_irdy", p_rdy, 1);
    for (int i = 0; i < 3; i++) begin
      p_val = 1; p_dat = 8'(8'hC0 + i); p_eop = (i == 2);
      step();
    end
    p_val = 0; p_eop = 0;
    chk("mr_new_pkts", p_pkts, 1);
    chk("mr_new_used", p_used, 3);
    p_ordy = 1;
    for (int i = 0; i < 3; i++) begin
      chk("mr_new_val", p_oval, 1);
      chk("mr_new_dat", p_odat, 8'hC0 + i);
      step();
    end
    chk("mr_new_end", p_used, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
